// File: rtl/histeq_frame_sequencer.sv
// Frame sequencer for histogram equalisation: clears the histogram RAM, gates pixel
// accumulation for one frame, then builds the saturating CDF into a double-buffered LUT.
module histeq_frame_sequencer #(
   parameter int BINS   = 256,
   parameter int CNT_W  = 19,
   parameter int RD_LAT = 1,
   parameter int ADDR_W = $clog2(BINS)
) (
   input  logic              iClk,
   input  logic              iRst,
   input  logic              iEnable,
   input  logic              iFval,
   input  logic              iDval,
   input  logic [CNT_W-1:0]  iHistRdData,
   output logic              oHistAddrSel,
   output logic [ADDR_W-1:0] oHistAddr,
   output logic              oHistClr,
   output logic              oHistRd,
   output logic              oAccumEn,
   output logic              oCdfWe,
   output logic [ADDR_W-1:0] oCdfAddr,
   output logic [CNT_W-1:0]  oCdfData,
   output logic              oCdfWrBank,
   output logic              oLutBank,
   output logic              oLutValid,
   output logic              oFrameSkip,
   output logic [15:0]       oFrameCount,
   output logic [2:0]        oState
);

   localparam int CW = ADDR_W + 1;

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_CLEAR    = 3'd1;
   localparam logic [2:0] S_WAIT_SOF = 3'd2;
   localparam logic [2:0] S_ACCUM    = 3'd3;
   localparam logic [2:0] S_CUMULATE = 3'd4;

   localparam logic [CW-1:0]     CLR_LAST  = CW'(BINS - 1);
   localparam logic [CW-1:0]     CUM_LAST  = CW'(BINS + RD_LAT - 1);
   localparam logic [CW-1:0]     RD_LAT_C  = CW'(RD_LAT);
   localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(BINS - 1);

   logic [2:0]        state_r;
   logic [2:0]        state_nxt_s;
   logic [CW-1:0]     cnt_r;
   logic [CW-1:0]     cnt_nxt_s;
   logic [CW-1:0]     cdf_idx_s;
   logic              fval_d_r;
   logic              sof_s;
   logic [CNT_W-1:0]  sum_r;
   logic [CNT_W-1:0]  sum_nxt_s;
   logic              hist_sel_nxt_s;
   logic [ADDR_W-1:0] hist_addr_nxt_s;
   logic              hist_clr_nxt_s;
   logic              hist_rd_nxt_s;
   logic              cdf_we_nxt_s;
   logic [ADDR_W-1:0] cdf_addr_nxt_s;
   logic [CNT_W-1:0]  cdf_data_nxt_s;
   logic              skip_nxt_s;
   logic              hist_sel_r;
   logic [ADDR_W-1:0] hist_addr_r;
   logic              hist_clr_r;
   logic              hist_rd_r;
   logic              cdf_we_r;
   logic [ADDR_W-1:0] cdf_addr_r;
   logic [CNT_W-1:0]  cdf_data_r;
   logic              skip_r;
   logic              lut_bank_r;
   logic              lut_valid_r;
   logic [15:0]       frame_cnt_r;

   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [CNT_W-1:0] b);
      logic [CNT_W:0] s;
      s = {1'b0, a} + {1'b0, b};
      if (s[CNT_W]) begin
         sat_add = {CNT_W{1'b1}};
      end else begin
         sat_add = s[CNT_W-1:0];
      end
   endfunction

   assign sof_s     = iFval & ~fval_d_r;
   assign cdf_idx_s = cnt_r - RD_LAT_C;

   // State, bin counter and frame-valid edge register
   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         state_r  <= S_IDLE;
         cnt_r    <= {CW{1'b0}};
         fval_d_r <= 1'b0;
      end else begin
         state_r  <= state_nxt_s;
         cnt_r    <= cnt_nxt_s;
         fval_d_r <= iFval;
      end
   end

   // Next-state and bin counter sequencing
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         S_IDLE: begin
            if (iEnable) state_nxt_s = S_CLEAR;
            else         state_nxt_s = S_IDLE;
         end
         S_CLEAR: begin
            if (cnt_r == CLR_LAST) begin
               if (iEnable) state_nxt_s = S_WAIT_SOF;
               else         state_nxt_s = S_IDLE;
            end else begin
               state_nxt_s = S_CLEAR;
            end
         end
         S_WAIT_SOF: begin
            if (!iEnable)   state_nxt_s = S_IDLE;
            else if (sof_s) state_nxt_s = S_ACCUM;
            else            state_nxt_s = S_WAIT_SOF;
         end
         // iEnable is deliberately ignored so a started frame always completes
         S_ACCUM: begin
            if (!iFval) state_nxt_s = S_CUMULATE;
            else        state_nxt_s = S_ACCUM;
         end
         S_CUMULATE: begin
            if (cnt_r == CUM_LAST) state_nxt_s = S_CLEAR;
            else                   state_nxt_s = S_CUMULATE;
         end
         default: state_nxt_s = S_IDLE;
      endcase

      if ((state_nxt_s == state_r) && ((state_r == S_CLEAR) || (state_r == S_CUMULATE))) begin
         cnt_nxt_s = cnt_r + CW'(1);
      end else begin
         cnt_nxt_s = {CW{1'b0}};
      end
   end

   // Next values of the registered outputs and the running sum
   always_comb begin
      hist_sel_nxt_s  = 1'b0;
      hist_addr_nxt_s = {ADDR_W{1'b0}};
      hist_clr_nxt_s  = 1'b0;
      hist_rd_nxt_s   = 1'b0;
      cdf_we_nxt_s    = 1'b0;
      cdf_addr_nxt_s  = {ADDR_W{1'b0}};
      cdf_data_nxt_s  = {CNT_W{1'b0}};
      skip_nxt_s      = 1'b0;
      sum_nxt_s       = sum_r;

      case (state_nxt_s)
         S_CLEAR: begin
            hist_sel_nxt_s  = 1'b1;
            hist_clr_nxt_s  = 1'b1;
            hist_addr_nxt_s = cnt_nxt_s[ADDR_W-1:0];
         end
         S_CUMULATE: begin
            if (cnt_nxt_s <= CLR_LAST) begin
               hist_sel_nxt_s  = 1'b1;
               hist_rd_nxt_s   = 1'b1;
               hist_addr_nxt_s = cnt_nxt_s[ADDR_W-1:0];
            end else begin
               hist_sel_nxt_s  = 1'b0;
               hist_rd_nxt_s   = 1'b0;
            end
         end
         default: begin
            hist_sel_nxt_s = 1'b0;
         end
      endcase

      // Read data for bin (cnt - RD_LAT) is on iHistRdData this cycle
      if ((state_r == S_CUMULATE) && (cnt_r >= RD_LAT_C)) begin
         sum_nxt_s      = sat_add(sum_r, iHistRdData);
         cdf_we_nxt_s   = 1'b1;
         cdf_addr_nxt_s = cdf_idx_s[ADDR_W-1:0];
         cdf_data_nxt_s = sum_nxt_s;
      end else if ((state_r == S_ACCUM) && !iFval) begin
         sum_nxt_s = {CNT_W{1'b0}};
      end else begin
         sum_nxt_s = sum_r;
      end

      if (sof_s && ((state_r == S_CLEAR) || (state_r == S_CUMULATE))) begin
         skip_nxt_s = 1'b1;
      end else begin
         skip_nxt_s = 1'b0;
      end
   end

   // Registered output strobes, CDF write port and running sum
   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         hist_sel_r  <= 1'b0;
         hist_addr_r <= {ADDR_W{1'b0}};
         hist_clr_r  <= 1'b0;
         hist_rd_r   <= 1'b0;
         cdf_we_r    <= 1'b0;
         cdf_addr_r  <= {ADDR_W{1'b0}};
         cdf_data_r  <= {CNT_W{1'b0}};
         skip_r      <= 1'b0;
         sum_r       <= {CNT_W{1'b0}};
      end else begin
         hist_sel_r  <= hist_sel_nxt_s;
         hist_addr_r <= hist_addr_nxt_s;
         hist_clr_r  <= hist_clr_nxt_s;
         hist_rd_r   <= hist_rd_nxt_s;
         cdf_we_r    <= cdf_we_nxt_s;
         cdf_addr_r  <= cdf_addr_nxt_s;
         cdf_data_r  <= cdf_data_nxt_s;
         skip_r      <= skip_nxt_s;
         sum_r       <= sum_nxt_s;
      end
   end

   // Publish the bank once its last entry has been presented with the old write bank
   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         lut_bank_r  <= 1'b0;
         lut_valid_r <= 1'b0;
         frame_cnt_r <= 16'd0;
      end else if (cdf_we_r && (cdf_addr_r == ADDR_LAST)) begin
         lut_bank_r  <= ~lut_bank_r;
         lut_valid_r <= 1'b1;
         frame_cnt_r <= frame_cnt_r + 16'd1;
      end else begin
         lut_bank_r  <= lut_bank_r;
         lut_valid_r <= lut_valid_r;
         frame_cnt_r <= frame_cnt_r;
      end
   end

   assign oAccumEn     = iDval & iFval &
                         ((state_r == S_ACCUM) | ((state_r == S_WAIT_SOF) & sof_s & iEnable));
   assign oCdfWrBank   = ~lut_bank_r;
   assign oHistAddrSel = hist_sel_r;
   assign oHistAddr    = hist_addr_r;
   assign oHistClr     = hist_clr_r;
   assign oHistRd      = hist_rd_r;
   assign oCdfWe       = cdf_we_r;
   assign oCdfAddr     = cdf_addr_r;
   assign oCdfData     = cdf_data_r;
   assign oLutBank     = lut_bank_r;
   assign oLutValid    = lut_valid_r;
   assign oFrameSkip   = skip_r;
   assign oFrameCount  = frame_cnt_r;
   assign oState       = state_r;

endmodule

// File: tb/tb_histeq_frame_sequencer.sv
// Directed bench for histeq_frame_sequencer: histogram RAM model with pixel
// accumulation, CDF capture, and hand-computed expected values.
module tb_histeq_frame_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        enable;
   logic        fval;
   logic        dval;
   logic [18:0] hist_rd_data = 19'd0;
   logic        hist_addr_sel;
   logic [7:0]  hist_addr;
   logic        hist_clr;
   logic        hist_rd;
   logic        accum_en;
   logic        cdf_we;
   logic [7:0]  cdf_addr;
   logic [18:0] cdf_data;
   logic        cdf_wr_bank;
   logic        lut_bank;
   logic        lut_valid;
   logic        frame_skip;
   logic [15:0] frame_count;
   logic [2:0]  state;

   logic [7:0]  pix = 8'd0;
   logic        sat_mode = 1'b0;
   logic [18:0] mem [256];
   logic [18:0] cdf [256];
   logic [7:0]  clr_expect = 8'd0;
   int n_clr = 0, n_cum = 0, n_acc = 0, n_skip = 0, n_wr = 0, clr_err = 0;
   int checks = 0, errors = 0;

   histeq_frame_sequencer dut (
      .iClk(clk), .iRst(rst), .iEnable(enable), .iFval(fval), .iDval(dval),
      .iHistRdData(hist_rd_data), .oHistAddrSel(hist_addr_sel), .oHistAddr(hist_addr),
      .oHistClr(hist_clr), .oHistRd(hist_rd), .oAccumEn(accum_en), .oCdfWe(cdf_we),
      .oCdfAddr(cdf_addr), .oCdfData(cdf_data), .oCdfWrBank(cdf_wr_bank),
      .oLutBank(lut_bank), .oLutValid(lut_valid), .oFrameSkip(frame_skip),
      .oFrameCount(frame_count), .oState(state)
   );

   always #5 clk = ~clk;

   // Histogram RAM model (clear, pixel increment, 1-cycle read) and event monitor
   always @(posedge clk) begin
      if (hist_clr) begin
         mem[hist_addr] <= 19'd0;
         n_clr <= n_clr + 1;
         if (hist_addr !== clr_expect) clr_err <= clr_err + 1;
         clr_expect <= hist_addr + 8'd1;
      end
      if (accum_en) begin
         mem[pix] <= mem[pix] + 19'd1;
         n_acc <= n_acc + 1;
      end
      if (hist_rd) hist_rd_data <= sat_mode ? 19'h7FFFF : mem[hist_addr];
      if (cdf_we) begin
         cdf[cdf_addr] <= cdf_data;
         n_wr <= n_wr + 1;
      end
      if (state == 3'd4) n_cum <= n_cum + 1;
      if (frame_skip) n_skip <= n_skip + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic wait_state(input logic [2:0] s, input int limit, input string tag);
      int n = 0;
      while (state !== s && n < limit) begin
         @(negedge clk);
         n++;
      end
      check(tag, {29'd0, state}, {29'd0, s});
   endtask

   initial begin
      logic [11:0] dmask;
      int acc0, clr0, cum0, skip0, wr0, bad, nacc, n;

      rst = 1'b1; enable = 1'b0; fval = 1'b0; dval = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_state", {29'd0, state}, 32'd0);
      check("rst_wrbank", {31'd0, cdf_wr_bank}, 32'd1);
      rst = 1'b0;
      @(negedge clk);
      check("idle_state", {29'd0, state}, 32'd0);
      check("idle_strobes", {27'd0, hist_addr_sel, hist_clr, hist_rd, cdf_we, frame_skip}, 32'd0);
      check("idle_lutbank", {31'd0, lut_bank}, 32'd0);
      check("idle_wrbank", {31'd0, cdf_wr_bank}, 32'd1);
      check("idle_fcount", {16'd0, frame_count}, 32'd0);
      check("idle_lutvalid", {31'd0, lut_valid}, 32'd0);

      // Clear sweep
      clr0 = n_clr;
      enable = 1'b1;
      wait_state(3'd2, 600, "clear_to_wait");
      check("clear_cycles", n_clr - clr0, 32'd256);
      check("clear_order", clr_err, 32'd0);

      // Frame 1: 12 valid lines, 8 pixels (five in bin 3, three in bin 10)
      dmask = 12'b011011011011;
      acc0 = n_acc;
      nacc = 0;
      for (int k = 0; k < 12; k++) begin
         fval = 1'b1;
         dval = dmask[k];
         pix  = (nacc < 5) ? 8'd3 : 8'd10;
         if (dmask[k]) nacc++;
         #1;
         if (k == 0) check("accum_on_sof", {31'd0, accum_en}, 32'd1);
         @(negedge clk);
      end
      check("frame1_accum", n_acc - acc0, 32'd8);

      // Frame fall, then frame 2 arrives 100 cycles later during CUMULATE
      cum0 = n_cum; acc0 = n_acc; skip0 = n_skip; wr0 = n_wr;
      for (int i = 0; i < 300; i++) begin
         fval = (i >= 100 && i < 112);
         dval = fval;
         pix  = 8'd20;
         @(negedge clk);
      end
      check("cum_cycles", n_cum - cum0, 32'd257);
      check("cdf_writes", n_wr - wr0, 32'd256);
      check("cdf2", {13'd0, cdf[2]}, 32'd0);
      check("cdf3", {13'd0, cdf[3]}, 32'd5);
      check("cdf9", {13'd0, cdf[9]}, 32'd5);
      check("cdf10", {13'd0, cdf[10]}, 32'd8);
      check("cdf255", {13'd0, cdf[255]}, 32'd8);
      check("f1_lutbank", {31'd0, lut_bank}, 32'd1);
      check("f1_wrbank", {31'd0, cdf_wr_bank}, 32'd0);
      check("f1_lutvalid", {31'd0, lut_valid}, 32'd1);
      check("f1_fcount", {16'd0, frame_count}, 32'd1);
      check("f2_skip", n_skip - skip0, 32'd1);
      check("f2_no_accum", n_acc - acc0, 32'd0);

      // Frame 3: accumulated normally, cumulated against a saturated RAM
      wait_state(3'd2, 400, "f3_wait");
      acc0 = n_acc;
      for (int k = 0; k < 6; k++) begin
         fval = 1'b1; dval = 1'b1; pix = 8'd0;
         @(negedge clk);
      end
      fval = 1'b0; dval = 1'b0; sat_mode = 1'b1;
      n = 0;
      while (frame_count !== 16'd2 && n < 600) begin
         @(negedge clk);
         n++;
      end
      sat_mode = 1'b0;
      check("f3_accum", n_acc - acc0, 32'd6);
      check("f3_fcount", {16'd0, frame_count}, 32'd2);
      check("f3_lutbank", {31'd0, lut_bank}, 32'd0);
      check("sat_cdf0", {13'd0, cdf[0]}, 32'd524287);
      check("sat_cdf255", {13'd0, cdf[255]}, 32'd524287);
      bad = 0;
      for (int b = 0; b < 256; b++) if (cdf[b] !== 19'h7FFFF) bad++;
      check("sat_all", bad, 32'd0);

      // Frame 4: asynchronous reset at bin 100 of CUMULATE
      wait_state(3'd2, 400, "f4_wait");
      for (int k = 0; k < 4; k++) begin
         fval = 1'b1; dval = 1'b1; pix = 8'd1;
         @(negedge clk);
      end
      fval = 1'b0; dval = 1'b0;
      wait_state(3'd4, 10, "f4_cumulate");
      n = 0;
      while (!(hist_rd === 1'b1 && hist_addr === 8'd100) && n < 300) begin
         @(negedge clk);
         n++;
      end
      check("f4_at_bin100", {24'd0, hist_addr}, 32'd100);
      rst = 1'b1;
      #1;
      check("arst_state", {29'd0, state}, 32'd0);
      check("arst_lutvalid", {31'd0, lut_valid}, 32'd0);
      check("arst_lutbank", {31'd0, lut_bank}, 32'd0);
      check("arst_cdfwe", {31'd0, cdf_we}, 32'd0);
      enable = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      wr0 = n_wr;
      repeat (300) @(negedge clk);
      check("arst_no_writes", n_wr - wr0, 32'd0);
      check("arst_idle", {29'd0, state}, 32'd0);
      check("arst_fcount", {16'd0, frame_count}, 32'd0);

      // Frame 5: enable dropped in ACCUM, loop completes then idles
      enable = 1'b1;
      wait_state(3'd2, 400, "f5_wait");
      acc0 = n_acc;
      for (int k = 0; k < 5; k++) begin
         fval = 1'b1; dval = 1'b1; pix = 8'd7;
         if (k == 1) enable = 1'b0;
         @(negedge clk);
      end
      fval = 1'b0; dval = 1'b0;
      clr0 = n_clr;
      wait_state(3'd4, 10, "f5_cumulate");
      wait_state(3'd1, 400, "f5_clear");
      wait_state(3'd0, 400, "f5_idle");
      check("f5_accum", n_acc - acc0, 32'd5);
      check("f5_clear_cycles", n_clr - clr0, 32'd256);
      check("f5_fcount", {16'd0, frame_count}, 32'd1);
      check("f5_lutvalid", {31'd0, lut_valid}, 32'd1);
      check("f5_lutbank", {31'd0, lut_bank}, 32'd1);
      check("f5_cdf6", {13'd0, cdf[6]}, 32'd0);
      check("f5_cdf7", {13'd0, cdf[7]}, 32'd5);
      check("f5_cdf255", {13'd0, cdf[255]}, 32'd5);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/histeq_frame_sequencer.md
Name: histeq_frame_sequencer

Overview:
- Sequences the histogram-equalisation datapath between the camera pixel stream and the display mux, one frame at a time.
- Clears the shared histogram RAM, gates per-pixel accumulation during a frame, then walks the 256 bins to build the cumulative (CDF) lookup table.
- The CDF is written into a double-buffered LUT, so the apply stage always reads a complete table.

Parameters:
- BINS, 256, number of histogram bins; address width ADDR_W = 8 is derived.
- CNT_W, 19, bin and CDF count width; covers 800x480 = 384000 pixels.
- RD_LAT, 1, histogram RAM read latency in cycles; only 1 is required.

Ports:
- iClk  in  1  pixel clock.
- iRst  in  1  asynchronous reset, active-high.
- iEnable  in  1  run the equalisation loop.
- iFval  in  1  frame valid.
- iDval  in  1  pixel valid.
- iHistRdData  in  CNT_W  histogram RAM read data.
- oHistAddrSel  out  1  1 = sequencer drives the histogram RAM address; 0 = pixel datapath drives it.
- oHistAddr  out  ADDR_W  sequencer histogram address.
- oHistClr  out  1  write zero at oHistAddr.
- oHistRd  out  1  read strobe at oHistAddr.
- oAccumEn  out  1  increment enable for the pixel datapath.
- oCdfWe  out  1  CDF write enable.
- oCdfAddr  out  ADDR_W  CDF write address.
- oCdfData  out  CNT_W  inclusive running sum.
- oCdfWrBank  out  1  LUT bank being written; always equals ~oLutBank.
- oLutBank  out  1  LUT bank valid for the apply stage.
- oLutValid  out  1  at least one CDF has completed since reset.
- oFrameSkip  out  1  one-cycle pulse when a frame start is missed.
- oFrameCount  out  16  number of completed CDFs; wraps at 65535 -> 0.
- oState  out  3  current state, for debug.

Behaviour:
- Reset (asynchronous): state IDLE, every output 0 (oCdfWrBank = 1), sum register 0, iFval edge register 0.
- States and encodings: IDLE=0, CLEAR=1, WAIT_SOF=2, ACCUM=3, CUMULATE=4.
- iFval rising edge (sof) is detected from a registered copy of iFval.
- IDLE:
  - all strobes low.
  - iEnable=1 -> CLEAR.
- CLEAR:
  - 256 cycles; oHistAddrSel=1, oHistClr=1, oHistAddr = 0..255 in order.
  - After address 255: iEnable=1 -> WAIT_SOF; otherwise -> IDLE.
  - A sof seen in CLEAR pulses oFrameSkip.
- WAIT_SOF:
  - oHistAddrSel=0.
  - sof -> ACCUM on the next cycle; the first pixel of the frame is accepted in that same edge cycle.
  - iEnable=0 -> IDLE.
- ACCUM:
  - oHistAddrSel=0, oAccumEn = iDval & iFval, combinational with zero latency.
  - iFval low -> CUMULATE, sum cleared to 0.
  - iEnable is ignored here; the loop runs to completion.
- CUMULATE (BINS+RD_LAT = 257 cycles):
  - Cycle k, k = 0..255: oHistAddrSel=1, oHistRd=1, oHistAddr=k.
  - Cycle k+1: sum <= sat(sum + iHistRdData); oCdfWe=1, oCdfAddr=k, oCdfData = sat(sum + iHistRdData).
  - sat() clamps to 2^CNT_W-1 with no wrap; the addition is computed CNT_W+1 wide.
  - In the cycle after the write to address 255: oLutBank toggles, oLutValid <= 1, oFrameCount increments, then -> CLEAR.
  - A sof seen in CUMULATE pulses oFrameSkip.
- Frames whose start falls in CUMULATE or CLEAR are not accumulated. The sequencer re-arms only on the next sof after reaching WAIT_SOF, so no partial frames are ever accumulated. Vertical blanking of at least 514 cycles is required for back-to-back frames.
- Enabling while iFval=1 results in CLEAR, then WAIT_SOF waiting for the next rising edge.
- Reset at any time, including mid-CUMULATE, immediately returns to IDLE. oLutValid is cleared; the partially written CDF bank is not published.
- Outputs are registered except oAccumEn and oCdfWrBank.

Test Plan:
- Reset asserted, then released with iEnable=0 -> oState=0, all strobes 0, oLutBank=0, oCdfWrBank=1, oFrameCount=0.
- iEnable=1 -> exactly 256 cycles of oHistClr=1 with oHistAddr 0..255, then oState=2.
- Frame with iFval high for 12 cycles and iDval high on 8 of them -> oAccumEn high exactly 8 cycles; at iFval fall, CUMULATE runs. RAM model returns bin3=5, bin10=3, others 0 -> CDF[2]=0, CDF[3]=5, CDF[9]=5, CDF[10]=8, CDF[255]=8. oLutBank goes 0->1, oLutValid=1, oFrameCount=1, 257 CUMULATE cycles observed.
- Second frame starts 100 cycles after the first frame ends (during CUMULATE) -> one oFrameSkip pulse, oAccumEn stays 0 for that frame; the third frame is accumulated normally.
- RAM model returns 2^19-1 for every bin -> CDF[0]=524287 and all later entries 524287 (saturated, no wrap).
- iRst pulsed at bin 100 of CUMULATE -> asynchronous return to IDLE; oLutValid=0, oLutBank=0, no further oCdfWe.
- iEnable dropped during ACCUM -> CUMULATE and CLEAR complete, then IDLE; oFrameCount increments by 1.
